// File: rtl/stream_out.sv
// Streams len buffer words through a small FIFO onto an AXI-Stream master port.
// Define STREAM_OUT_TLAST_EN to drive m_axis_tlast on the final beat; otherwise it is tied low.
module stream_out #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       len,
  output logic             stream_v,
  output logic [7:0]       stream_a,
  input  logic [WIDTH-1:0] stream_d,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [8:0]       len_q;
  logic [8:0]       issued;
  logic [8:0]       sent;
  logic             inflight;
  logic             zero_done;
  logic             last_sent;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // The in-flight read already owns a FIFO slot, so it is counted before issuing another.
  assign stream_v = (state == S_ISSUE) && (issued != len_q) &&
                    ((count + CW'(inflight)) < CW'(DEPTH));
  assign stream_a = issued[7:0];

  assign push          = inflight;
  assign m_axis_tvalid = (count != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;

  assign last_sent = (state == S_DRAIN) && (sent == len_q);
  assign done      = zero_done || last_sent;
  assign busy      = (state != S_IDLE) && !last_sent;

`ifdef STREAM_OUT_TLAST_EN
  assign m_axis_tlast = m_axis_tvalid && (sent == (len_q - 9'd1));
`else
  assign m_axis_tlast = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      issued    <= '0;
      sent      <= '0;
      inflight  <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      inflight  <= stream_v;
      if (stream_v) issued <= issued + 9'd1;
      if (pop)      sent   <= sent + 9'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != 8'd0) begin
              len_q  <= {1'b0, len};
              issued <= '0;
              sent   <= '0;
              state  <= S_ISSUE;
            end else begin
              zero_done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (stream_v && ((issued + 9'd1) == len_q)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_sent) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; tdata is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stream_d;
  end

endmodule
